tx_frame_sequencer: RTL and testbench

- Drives the 802.11a transmitter front-end, which sends the preamble, captures the length, scrambles data and counts pad bytes. The front-end's inputs are Enable, x (serial) and num_pads.
- Accepts a frame request (rate, length), pulls payload bytes over a valid/ready byte stream and serialises the bit stream MSB-first: SIGNAL header, payload, service/tail, pad.
- Frames the stream with Enable and enforces an inter-frame gap.

---
 rtl/tx_seq_pkg.sv | 29 ++
 rtl/tx_pad_calc.sv | 27 ++
 rtl/tx_frame_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared state encoding, frame constants and header builder
// for the 802.11a transmit frame sequencer.
package tx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_TAIL,
    S_FLUSH,
    S_GAP
  } state_t;

  localparam int PRE_BITS   = 12;
  localparam int HDR_BITS   = 24;
  localparam int TAIL_BYTES = 2;

  // SIGNAL word, bit 0 of the header sits in the MSB
  function automatic logic [HDR_BITS-1:0] hdr_word(
    input logic [3:0]  rate,
    input logic [11:0] len
  );
    logic par;
    par = ^{rate, len};
    return {rate, 1'b0, len, par, 6'b000000};
  endfunction

endpackage

// File: rtl/tx_pad_calc.sv
// tx_pad_calc: maps payload length to pad bytes for one OFDM block size
// and flags whether the length is acceptable.
module tx_pad_calc
  import tx_seq_pkg::*;
#(
  parameter int BLOCK_BYTES = 3,
  parameter int MAX_LEN     = 1012
) (
  input  logic [11:0] len_i,
  output logic [2:0]  pads_o,
  output logic        legal_o
);

  logic [12:0] tot;
  logic [12:0] rem;
  logic [12:0] pad_w;

  // pad = bytes needed to round L+5 up to a block multiple
  always_comb begin
    tot     = 13'(len_i) + 13'd5;
    rem     = tot % 13'(BLOCK_BYTES);
    pad_w   = (13'(BLOCK_BYTES) - rem) % 13'(BLOCK_BYTES);
    pads_o  = pad_w[2:0];
    legal_o = (len_i != 12'd0) && (13'(len_i) <= 13'(MAX_LEN));
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: serialises preamble fill, SIGNAL header, payload,
// tail and pad into the 802.11a transmitter Enable/x/num_pads inputs.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int BLOCK_BYTES = 3,
  parameter int MAX_LEN     = 1012,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_rate,
  input  logic [11:0] req_length,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        tx_enable,
  output logic        tx_x,
  output logic [2:0]  tx_num_pads,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_underrun
);

  // The IDLE cycle itself is one of the low-Enable gap cycles,
  // so the GAP state only covers the remaining GAP_CYCLES-1.
  localparam state_t S_AFTER =
    (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
  localparam logic [12:0] PRE_LAST = 13'(PRE_BITS - 1);
  localparam logic [12:0] HDR_LAST = 13'(HDR_BITS - 1);
  localparam logic [12:0] GAP_LAST =
    13'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bib_q, bib_d;
  logic [11:0] fetched_q, fetched_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] len_q, len_d;
  logic [2:0]  pads_q, pads_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_v_q, buf_v_d;
  logic [7:0]  sh_q, sh_d;
  logic        done_q, done_d;
  logic        err_len_q, err_len_d;

  logic [2:0]  calc_pads;
  logic        calc_legal;
  logic        accept;
  logic        start;
  logic        boundary;
  logic        underrun;
  logic        fetch;
  logic [HDR_BITS-1:0] hdr;
  logic [14:0] pay_bits;
  logic [12:0] pay_last;
  logic [12:0] tail_last;

  tx_pad_calc #(
    .BLOCK_BYTES(BLOCK_BYTES),
    .MAX_LEN    (MAX_LEN)
  ) u_pad (
    .len_i  (req_length),
    .pads_o (calc_pads),
    .legal_o(calc_legal)
  );

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign start     = accept && calc_legal;
  assign boundary  = (state_q == S_PAY) && (bib_q == 3'd0);
  assign underrun  = boundary && !buf_v_q;
  assign hdr       = hdr_word(rate_q, len_q);
  assign pay_bits  = {len_q, 3'b000};
  assign pay_last  = 13'(pay_bits - 15'd1);
  assign tail_last = 13'((13'(pads_q) + 13'(TAIL_BYTES))
                         * 13'd8 - 13'd1);

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign byte_ready   = (state_q inside {S_PRE, S_HDR, S_PAY})
                        && !buf_v_q && (fetched_q < len_q);
  assign fetch        = byte_valid && byte_ready;
  assign tx_num_pads  = pads_q;
  assign done         = done_q;
  assign err_len      = err_len_q;
  assign err_underrun = underrun;

  // Frame FSM: phase sequencing and Enable/x generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 13'd1;
    tx_enable = 1'b0;
    tx_x      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_PRE;
      end
      S_PRE: begin
        tx_enable = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        tx_enable = 1'b1;
        tx_x      = hdr[5'(HDR_LAST) - cnt_q[4:0]];
        if (cnt_q == HDR_LAST) begin
          state_d = S_PAY;
          cnt_d   = '0;
        end
      end
      S_PAY: begin
        if (underrun) begin
          state_d = S_AFTER;
          cnt_d   = '0;
        end else begin
          tx_enable = 1'b1;
          tx_x      = boundary ? buf_q[7] : sh_q[7];
          if (cnt_q == pay_last) begin
            state_d = S_TAIL;
            cnt_d   = '0;
          end
        end
      end
      S_TAIL: begin
        tx_enable = 1'b1;
        if (cnt_q == tail_last) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        tx_enable = 1'b1;
        state_d   = S_AFTER;
        cnt_d     = '0;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch, prefetch buffer, byte shifter and status pulses
  always_comb begin
    rate_d    = rate_q;
    len_d     = len_q;
    pads_d    = pads_q;
    fetched_d = fetched_q;
    buf_d     = buf_q;
    buf_v_d   = buf_v_q;
    sh_d      = sh_q;
    bib_d     = bib_q;
    done_d    = (state_q == S_FLUSH);
    err_len_d = accept && !calc_legal;
    if (start) begin
      rate_d    = req_rate;
      len_d     = req_length;
      pads_d    = calc_pads;
      fetched_d = '0;
      buf_v_d   = 1'b0;
      bib_d     = '0;
    end
    if ((state_q == S_PAY) && !underrun) begin
      bib_d = bib_q + 3'd1;
      if (boundary) begin
        sh_d    = {buf_q[6:0], 1'b0};
        buf_v_d = 1'b0;
      end else begin
        sh_d = {sh_q[6:0], 1'b0};
      end
    end
    if (fetch) begin
      buf_d     = byte_data;
      buf_v_d   = 1'b1;
      fetched_d = fetched_q + 12'd1;
    end
    if (underrun) begin
      fetched_d = '0;
      buf_v_d   = 1'b0;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bib_q     <= '0;
      fetched_q <= '0;
      rate_q    <= '0;
      len_q     <= '0;
      pads_q    <= '0;
      buf_q     <= '0;
      buf_v_q   <= 1'b0;
      sh_q      <= '0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bib_q     <= bib_d;
      fetched_q <= fetched_d;
      rate_q    <= rate_d;
      len_q     <= len_d;
      pads_q    <= pads_d;
      buf_q     <= buf_d;
      buf_v_q   <= buf_v_d;
      sh_q      <= sh_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: table vectors, hand sequences and randomized
// frames checked against a bit-stream reference model.
module tb_tx_frame_sequencer;

  localparam int BB   = 3;
  localparam int GAP  = 2;
  localparam int MAXL = 1012;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_rate = '0;
  logic [11:0] req_length = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        req_ready, byte_ready, tx_enable, tx_x;
  logic        busy, done, err_len, err_underrun;
  logic [2:0]  tx_num_pads;

  tx_frame_sequencer #(
    .BLOCK_BYTES(BB),
    .MAX_LEN    (MAXL),
    .GAP_CYCLES (GAP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rate    (req_rate),
    .req_length  (req_length),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .tx_enable   (tx_enable),
    .tx_x        (tx_x),
    .tx_num_pads (tx_num_pads),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len),
    .err_underrun(err_underrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] rate;
    int         len;
    int         drop;
    bit         a5;
    int         en;
    int         bsy;
    int         pads;
    int         dn;
    int         ur;
    int         el;
    int         fet;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] pay[$];
  bit         exp_q[$];
  bit         got_q[$];
  int  src_idx, drop_at, lows;
  bit  stall;
  int  cyc = 0;
  int  en_cyc, rises, gap_meas, last_hi, busy_cyc, rdy_low;
  int  done_n, undr_n, elen_n;
  bit  prev_en = 1'b0;
  bit  last_busy = 1'b0;

  task automatic chk(input string nm, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, expv);
  endtask

  task automatic chk_stream(input string nm, input int n);
    int bad;
    bad = -1;
    n_chk++;
    if (got_q.size() != n || exp_q.size() < n) bad = -2;
    else
      for (int i = 0; i < n; i++)
        if (bad == -1 && got_q[i] != exp_q[i]) bad = i;
    if (bad == -1) n_pass++;
    else $display("FAIL %s: got %0d bits (first bad %0d) expected %0d bits",
                  nm, got_q.size(), bad, n);
  endtask

  function automatic int outs();
    return int'({tx_enable, tx_x, tx_num_pads, byte_ready, busy,
                 done, err_len, err_underrun, req_ready});
  endfunction

  function automatic int model_pads(input int L);
    for (int p = 0; p < BB; p++)
      if ((L + 5 + p) % BB == 0) return p;
    return -1;
  endfunction

  task automatic build_exp(input logic [3:0] rate, input int L);
    bit h[$];
    int ones;
    exp_q.delete();
    repeat (12) exp_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) h.push_back(rate[i]);
    h.push_back(1'b0);
    for (int i = 11; i >= 0; i--) h.push_back(L[i]);
    ones = 0;
    foreach (h[i]) ones += int'(h[i]);
    h.push_back(ones % 2 == 1);
    repeat (6) h.push_back(1'b0);
    foreach (h[i]) exp_q.push_back(h[i]);
    for (int k = 0; k < L && k < pay.size(); k++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(pay[k][i]);
    repeat (8 * (2 + model_pads(L)) + 1) exp_q.push_back(1'b0);
  endtask

  task automatic upd_src();
    bit ok;
    ok = (src_idx < pay.size()) && !(drop_at >= 0 && src_idx >= drop_at);
    if (ok && stall && lows < 3 && $urandom_range(0, 2) == 0) begin
      ok = 1'b0;
      lows++;
    end else begin
      lows = 0;
    end
    byte_valid = ok;
    byte_data  = (src_idx < pay.size()) ? pay[src_idx] : 8'h00;
  endtask

  task automatic clr();
    got_q.delete();
    en_cyc = 0; rises = 0; gap_meas = -1; last_hi = 0;
    busy_cyc = 0; rdy_low = 0; done_n = 0; undr_n = 0; elen_n = 0;
  endtask

  task automatic step();
    bit fire;
    @(negedge Clk);
    fire = byte_valid && byte_ready;
    if (tx_enable) begin
      got_q.push_back(tx_x);
      en_cyc++;
      if (!prev_en) begin
        rises++;
        gap_meas = cyc - last_hi;
      end
      last_hi = cyc;
    end
    prev_en   = tx_enable;
    last_busy = busy;
    if (busy) busy_cyc++;
    if (!req_ready) rdy_low++;
    if (done) done_n++;
    if (err_underrun) undr_n++;
    if (err_len) elen_n++;
    @(posedge Clk);
    #1;
    cyc++;
    if (fire) src_idx++;
    upd_src();
  endtask

  task automatic run_frame(input logic [3:0] rate, input int L,
                           input int drop, input bit st, input bit a5);
    int t;
    pay.delete();
    for (int k = 0; k < L; k++)
      pay.push_back(a5 ? 8'hA5 : 8'($urandom));
    src_idx = 0; drop_at = drop; stall = st; lows = 0;
    clr();
    upd_src();
    req_rate = rate;
    req_length = 12'(L);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    t = 0;
    do begin
      step();
      t++;
    end while (last_busy && t < 9000);
    chk("frame_end_idle", int'(last_busy), 0);
  endtask

  initial begin
    vec_t tbl[9];
    int t;
    logic [3:0] r;
    int L;
    tbl[0] = '{4'b1101, 1,    -1, 1'b1, 61,   62,   0,  1, 0, 0, 1};
    tbl[1] = '{4'b0101, 2,    -1, 1'b0, 85,   86,   2,  1, 0, 0, 2};
    tbl[2] = '{4'b1011, 3,    -1, 1'b0, 85,   86,   1,  1, 0, 0, 3};
    tbl[3] = '{4'b0111, 4,    -1, 1'b0, 85,   86,   0,  1, 0, 0, 4};
    tbl[4] = '{4'b1001, 5,    -1, 1'b0, 109,  110,  2,  1, 0, 0, 5};
    tbl[5] = '{4'b1111, 3,     1, 1'b0, 44,   46,   1,  0, 1, 0, 1};
    tbl[6] = '{4'b1101, 0,    -1, 1'b0, 0,    0,    -1, 0, 0, 1, 0};
    tbl[7] = '{4'b1101, 1013, -1, 1'b0, 0,    0,    -1, 0, 0, 1, 0};
    tbl[8] = '{4'b0001, 1012, -1, 1'b0, 8149, 8150, 0,  1, 0, 0, 1012};

    src_idx = 0; drop_at = -1; stall = 0; lows = 0;
    clr();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_outputs", outs(), 1);
    @(posedge Clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].rate, tbl[i].len, tbl[i].drop, 1'b0, tbl[i].a5);
      build_exp(tbl[i].rate, tbl[i].len);
      chk_stream($sformatf("row%0d stream", i), tbl[i].en);
      chk($sformatf("row%0d busy_cycles", i), busy_cyc, tbl[i].bsy);
      chk($sformatf("row%0d ready_low", i), rdy_low, tbl[i].bsy);
      chk($sformatf("row%0d done", i), done_n, tbl[i].dn);
      chk($sformatf("row%0d err_underrun", i), undr_n, tbl[i].ur);
      chk($sformatf("row%0d err_len", i), elen_n, tbl[i].el);
      chk($sformatf("row%0d enable_rises", i), rises,
          (tbl[i].en > 0) ? 1 : 0);
      chk($sformatf("row%0d fetched", i), src_idx, tbl[i].fet);
      if (tbl[i].pads >= 0)
        chk($sformatf("row%0d num_pads", i), int'(tx_num_pads),
            tbl[i].pads);
    end

    // reset in HDR cycle 10, then an identical L=1 frame
    pay.delete();
    pay.push_back(8'hA5);
    src_idx = 0; drop_at = -1; stall = 0; lows = 0;
    clr();
    upd_src();
    req_rate = 4'b1101; req_length = 12'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (22) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("enable_before_reset", en_cyc, 23);
    @(negedge Clk);
    chk("mid_frame_reset_outputs", outs(), 1);
    @(posedge Clk);
    #1;
    run_frame(4'b1101, 1, -1, 1'b0, 1'b1);
    build_exp(4'b1101, 1);
    chk_stream("post_reset stream", 61);
    chk("post_reset done", done_n, 1);

    // back-to-back requests held valid
    pay.delete();
    pay.push_back(8'h3C);
    pay.push_back(8'hC3);
    src_idx = 0; drop_at = -1; stall = 0; lows = 0;
    clr();
    upd_src();
    req_rate = 4'b0011; req_length = 12'd1; req_valid = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (rises < 2 && t < 400);
    req_valid = 1'b0;
    do begin
      step();
      t++;
    end while (last_busy && t < 800);
    chk("b2b end_idle", int'(last_busy), 0);
    chk("b2b gap", gap_meas, GAP + 1);
    chk("b2b done", done_n, 2);
    chk("b2b enable_cycles", en_cyc, 122);

    // randomized frames with stalling byte source
    for (int n = 0; n < 25; n++) begin
      r = 4'($urandom);
      L = $urandom_range(1, 48);
      run_frame(r, L, -1, 1'b1, 1'b0);
      build_exp(r, L);
      chk_stream($sformatf("rnd%0d stream L=%0d", n, L), exp_q.size());
      chk($sformatf("rnd%0d busy_cycles", n), busy_cyc, exp_q.size() + GAP - 1);
      chk($sformatf("rnd%0d num_pads", n), int'(tx_num_pads), model_pads(L));
      chk($sformatf("rnd%0d done", n), done_n, 1);
      chk($sformatf("rnd%0d fetched", n), src_idx, L);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
